eth_tx_sched: RTL and testbench

Packet scheduler in front of the UDP transmit port, in the `gmii_tx_clk` domain. It shares one UDP TX channel between two packet sources: the image-format source (`f_`) and the image-data source (`i_`). It latches their start requests, grants the channel to one source at a time and holds the grant until the packet completes. It inserts a programmable inter-packet gap and recovers from a lost `tx_done` with a timeout. It replaces the plain `i_config_end` mux between the two sources.

---
 rtl/eth_tx_sched.sv | 185 ++++++++++++++++++
 tb/tb_eth_tx_sched.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_sched
// Purpose  : Shares one UDP TX channel between the image-format source (f_)
//            and the image-data source (i_). Start requests are latched as
//            pending flags with their byte counts. The channel is granted to
//            one source at a time, round-robin on ties, and held until the
//            packet completes. A programmable inter-packet gap follows each
//            packet. A SEND timeout recovers from a lost eth_tx_done.
// Ports    : sys_clk / sys_rst_n     clock, async active-low reset
//            config_end              format phase finished (gates image)
//            f_start/f_num/f_data    format source request, count, data
//            i_start/i_num/i_data    image source request, count, data
//            eth_tx_req/eth_tx_done  UDP block data request / done pulse
//            eth_tx_start/_data_num  UDP block start pulse and byte count
//            eth_tx_data             muxed TX data to the UDP block
//            f_/i_tx_req, f_/i_tx_done  per-source request / done routing
//            grant, busy, tmo_err, pkt_cnt  status
// Revision : 1.0  initial release
// ============================================================================
module eth_tx_sched #(
    parameter logic [15:0] GAP_CYC = 16'd12,
    parameter logic [23:0] TMO_CYC = 24'd1_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        config_end,
    input  logic        f_start,
    input  logic [15:0] f_num,
    input  logic [31:0] f_data,
    input  logic        i_start,
    input  logic [15:0] i_num,
    input  logic [31:0] i_data,
    input  logic        eth_tx_req,
    input  logic        eth_tx_done,
    output logic        eth_tx_start,
    output logic [15:0] eth_tx_data_num,
    output logic [31:0] eth_tx_data,
    output logic        f_tx_req,
    output logic        i_tx_req,
    output logic        f_tx_done,
    output logic        i_tx_done,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        tmo_err,
    output logic [15:0] pkt_cnt
);

    localparam logic [23:0] TMO_LAST = TMO_CYC - 24'd1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_SEND  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t      state;
    logic        f_pend;
    logic        i_pend;
    logic [15:0] f_cnt;
    logic [15:0] i_cnt;
    logic        last_img;   // 1: image was granted last
    logic        cfg_q;      // config_end aligned with the pending-flag stage
    logic [23:0] tmo_cnt;
    logic [15:0] gap_cnt;

    logic in_send;
    logic f_own;
    logic i_own;
    logic tmo_hit;
    logic pkt_end;
    logic f_elig;
    logic i_elig;
    logic pick_f;
    logic f_set;
    logic i_set;

    assign in_send = (state == S_SEND);
    assign f_own   = (grant == 2'b01);
    assign i_own   = (grant == 2'b10);
    // A real done in the last timeout cycle counts as a normal completion.
    assign tmo_hit = in_send && !eth_tx_done && (tmo_cnt == TMO_LAST);
    assign pkt_end = in_send && (eth_tx_done || tmo_hit);

    assign f_tx_req  = in_send && f_own && eth_tx_req;
    assign i_tx_req  = in_send && i_own && eth_tx_req;
    assign f_tx_done = pkt_end && f_own;
    assign i_tx_done = pkt_end && i_own;
    assign tmo_err   = tmo_hit;
    assign busy      = (state != S_IDLE);

    always_comb begin
        eth_tx_data = 32'd0;
        case (grant)
            2'b01:   eth_tx_data = f_data;
            2'b10:   eth_tx_data = i_data;
            default: eth_tx_data = 32'd0;
        endcase
    end

    // A new start is accepted when the flag is free or is being cleared in
    // this very cycle, so a re-request on the own done is never lost.
    assign f_set  = f_start && (!f_pend || f_tx_done);
    assign i_set  = i_start && (!i_pend || i_tx_done);

    assign f_elig = f_pend;
    assign i_elig = i_pend && cfg_q;
    assign pick_f = f_elig && (!i_elig || last_img);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            f_pend <= 1'b0;
            i_pend <= 1'b0;
            f_cnt  <= 16'd0;
            i_cnt  <= 16'd0;
            cfg_q  <= 1'b0;
        end else begin
            cfg_q <= config_end;
            if (f_set) begin
                f_pend <= 1'b1;
                f_cnt  <= f_num;
            end else if (f_tx_done) begin
                f_pend <= 1'b0;
            end
            if (i_set) begin
                i_pend <= 1'b1;
                i_cnt  <= i_num;
            end else if (i_tx_done) begin
                i_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state           <= S_IDLE;
            grant           <= 2'b00;
            last_img        <= 1'b1;
            eth_tx_start    <= 1'b0;
            eth_tx_data_num <= 16'd0;
            pkt_cnt         <= 16'd0;
            tmo_cnt         <= 24'd0;
            gap_cnt         <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (f_elig || i_elig) begin
                        grant           <= pick_f ? 2'b01 : 2'b10;
                        last_img        <= !pick_f;
                        eth_tx_start    <= 1'b1;
                        eth_tx_data_num <= pick_f ? f_cnt : i_cnt;
                        state           <= S_START;
                    end
                end
                S_START: begin
                    eth_tx_start <= 1'b0;
                    tmo_cnt      <= 24'd0;
                    state        <= S_SEND;
                end
                S_SEND: begin
                    tmo_cnt <= tmo_cnt + 24'd1;
                    if (eth_tx_done) begin
                        pkt_cnt <= pkt_cnt + 16'd1;
                    end
                    if (pkt_end) begin
                        grant   <= 2'b00;
                        gap_cnt <= GAP_CYC;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 16'd0) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_tx_sched
// Purpose  : Directed self-checking bench for eth_tx_sched. Every expected
//            grant/byte count is queued when a start is driven and compared
//            when eth_tx_start appears.
// Revision : 1.0  initial release
// ============================================================================
module tb_eth_tx_sched;

    localparam logic [15:0] GAP = 16'd4;
    localparam logic [23:0] TMO = 24'd100;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        config_end = 1'b0;
    logic        f_start = 1'b0;
    logic [15:0] f_num = 16'd0;
    logic [31:0] f_data = 32'd0;
    logic        i_start = 1'b0;
    logic [15:0] i_num = 16'd0;
    logic [31:0] i_data = 32'd0;
    logic        eth_tx_req = 1'b0;
    logic        eth_tx_done = 1'b0;
    logic        eth_tx_start;
    logic [15:0] eth_tx_data_num;
    logic [31:0] eth_tx_data;
    logic        f_tx_req;
    logic        i_tx_req;
    logic        f_tx_done;
    logic        i_tx_done;
    logic [1:0]  grant;
    logic        busy;
    logic        tmo_err;
    logic [15:0] pkt_cnt;

    eth_tx_sched #(
        .GAP_CYC (GAP),
        .TMO_CYC (TMO)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .config_end      (config_end),
        .f_start         (f_start),
        .f_num           (f_num),
        .f_data          (f_data),
        .i_start         (i_start),
        .i_num           (i_num),
        .i_data          (i_data),
        .eth_tx_req      (eth_tx_req),
        .eth_tx_done     (eth_tx_done),
        .eth_tx_start    (eth_tx_start),
        .eth_tx_data_num (eth_tx_data_num),
        .eth_tx_data     (eth_tx_data),
        .f_tx_req        (f_tx_req),
        .i_tx_req        (i_tx_req),
        .f_tx_done       (f_tx_done),
        .i_tx_done       (i_tx_done),
        .grant           (grant),
        .busy            (busy),
        .tmo_err         (tmo_err),
        .pkt_cnt         (pkt_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          prev_start_cyc = 0;
    bit          saw_start = 1'b0;
    logic [17:0] sb[$];   // {grant, byte count} in expected grant order

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 time unit after the rising edge and run the
    // scoreboard whenever a start pulse is seen.
    task automatic tick();
        logic [17:0] e;
        @(posedge sys_clk);
        #1;
        cyc++;
        saw_start = (eth_tx_start === 1'b1);
        if (saw_start) begin
            prev_start_cyc = start_cyc;
            start_cyc      = cyc;
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL sb_unexpected_start: observed grant %0h num %0d expected no start",
                       grant, eth_tx_data_num);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_grant", {30'd0, grant}, {30'd0, e[17:16]});
                chk("sb_num", {16'd0, eth_tx_data_num}, {16'd0, e[15:0]});
            end
        end
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!saw_start && n < 200);
        chk({tag, "_wait_start"}, {31'd0, saw_start}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_wait_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_start"},  {31'd0, eth_tx_start}, 32'd0);
        chk({tag, "_num"},    {16'd0, eth_tx_data_num}, 32'd0);
        chk({tag, "_data"},   eth_tx_data, 32'd0);
        chk({tag, "_freq"},   {31'd0, f_tx_req}, 32'd0);
        chk({tag, "_ireq"},   {31'd0, i_tx_req}, 32'd0);
        chk({tag, "_fdone"},  {31'd0, f_tx_done}, 32'd0);
        chk({tag, "_idone"},  {31'd0, i_tx_done}, 32'd0);
        chk({tag, "_grant"},  {30'd0, grant}, 32'd0);
        chk({tag, "_busy"},   {31'd0, busy}, 32'd0);
        chk({tag, "_tmo"},    {31'd0, tmo_err}, 32'd0);
        chk({tag, "_pktcnt"}, {16'd0, pkt_cnt}, 32'd0);
    endtask

    // Called in START. Holds SEND for len cycles (len-1 request cycles then
    // the done cycle), optionally re-requesting in the done cycle.
    task automatic do_pkt(input logic [1:0] own, input int len,
                          input bit rs_f, input bit rs_i, input logic [15:0] num);
        tick();
        for (int k = 0; k < len - 1; k++) begin
            eth_tx_req = 1'b1;
            #1;
            chk("route_freq", {31'd0, f_tx_req}, {31'd0, own[0]});
            chk("route_ireq", {31'd0, i_tx_req}, {31'd0, own[1]});
            chk("route_data", eth_tx_data, own[0] ? f_data : i_data);
            tick();
            eth_tx_req = 1'b0;
        end
        eth_tx_done = 1'b1;
        if (rs_f) begin
            f_start = 1'b1;
            f_num   = num;
            sb.push_back({2'b01, num});
        end
        if (rs_i) begin
            i_start = 1'b1;
            i_num   = num;
            sb.push_back({2'b10, num});
        end
        #1;
        chk("done_f", {31'd0, f_tx_done}, {31'd0, own[0]});
        chk("done_i", {31'd0, i_tx_done}, {31'd0, own[1]});
        chk("done_tmo_quiet", {31'd0, tmo_err}, 32'd0);
        tick();
        eth_tx_done = 1'b0;
        f_start     = 1'b0;
        i_start     = 1'b0;
        chk("gap_grant", {30'd0, grant}, 32'd0);
    endtask

    initial begin
        int s;
        int n;
        f_data = 32'hF0F0_0001;
        i_data = 32'h1234_5678;

        // Reset state
        repeat (3) @(posedge sys_clk);
        #1;
        chk_zero("rst");
        #2;
        sys_rst_n = 1'b1;
        tick();
        chk_zero("post_rst");

        // Format only, config_end low
        f_start = 1'b1;
        f_num   = 16'd16;
        sb.push_back({2'b01, 16'd16});
        tick();
        f_start = 1'b0;
        f_num   = 16'd0;
        tick();
        chk("t1_start_lat", {31'd0, eth_tx_start}, 32'd1);
        chk("t1_data_mux", eth_tx_data, 32'hF0F0_0001);
        do_pkt(2'b01, 3, 1'b0, 1'b0, 16'd0);
        chk("t1_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);
        chk("t1_gap_busy", {31'd0, busy}, 32'd1);
        wait_idle("t1");

        // Image held until config_end; second request while pending ignored
        i_start = 1'b1;
        i_num   = 16'd1280;
        tick();
        i_start = 1'b0;
        i_num   = 16'd0;
        repeat (3) tick();
        i_start = 1'b1;
        i_num   = 16'd999;
        tick();
        i_start = 1'b0;
        i_num   = 16'd0;
        repeat (6) tick();
        chk("t2_no_grant", {30'd0, grant}, 32'd0);
        chk("t2_idle", {31'd0, busy}, 32'd0);
        config_end = 1'b1;
        sb.push_back({2'b10, 16'd1280});
        tick();
        tick();
        chk("t2_cfg_lat", {31'd0, eth_tx_start}, 32'd1);
        chk("t2_data_mux", eth_tx_data, 32'h1234_5678);
        // Re-request in the same cycle as its own done
        do_pkt(2'b10, 4, 1'b0, 1'b1, 16'd77);
        chk("t2_pkt_cnt", {16'd0, pkt_cnt}, 32'd2);
        wait_start("t2_resend");
        do_pkt(2'b10, 2, 1'b0, 1'b0, 16'd0);
        chk("t2_pkt_cnt2", {16'd0, pkt_cnt}, 32'd3);
        wait_idle("t2");

        // Round robin, four packets
        f_start = 1'b1;
        f_num   = 16'd100;
        i_start = 1'b1;
        i_num   = 16'd200;
        sb.push_back({2'b01, 16'd100});
        sb.push_back({2'b10, 16'd200});
        tick();
        f_start = 1'b0;
        i_start = 1'b0;
        wait_start("rr0");
        do_pkt(2'b01, 5, 1'b1, 1'b0, 16'd101);
        wait_start("rr1");
        chk("rr1_spacing", {31'd0, (start_cyc - prev_start_cyc) >= 5 + int'(GAP) + 3}, 32'd1);
        do_pkt(2'b10, 3, 1'b0, 1'b1, 16'd201);
        wait_start("rr2");
        chk("rr2_spacing", {31'd0, (start_cyc - prev_start_cyc) >= 3 + int'(GAP) + 3}, 32'd1);
        do_pkt(2'b01, 2, 1'b0, 1'b0, 16'd0);
        wait_start("rr3");
        chk("rr3_spacing", {31'd0, (start_cyc - prev_start_cyc) >= 2 + int'(GAP) + 3}, 32'd1);
        do_pkt(2'b10, 2, 1'b0, 1'b0, 16'd0);
        chk("rr_pkt_cnt", {16'd0, pkt_cnt}, 32'd7);
        wait_idle("rr");

        // Timeout: format never gets a done, image is granted afterwards
        f_start = 1'b1;
        f_num   = 16'd300;
        i_start = 1'b1;
        i_num   = 16'd400;
        sb.push_back({2'b01, 16'd300});
        sb.push_back({2'b10, 16'd400});
        tick();
        f_start = 1'b0;
        i_start = 1'b0;
        wait_start("tmo0");
        s = start_cyc;
        n = 0;
        do begin
            tick();
            n++;
        end while (f_tx_done !== 1'b1 && n < 150);
        chk("tmo_delay", cyc - s, 32'd100);
        chk("tmo_err_pulse", {31'd0, tmo_err}, 32'd1);
        chk("tmo_idone_quiet", {31'd0, i_tx_done}, 32'd0);
        chk("tmo_pkt_cnt", {16'd0, pkt_cnt}, 32'd7);
        tick();
        chk("tmo_err_one_cycle", {31'd0, tmo_err}, 32'd0);
        chk("tmo_gap_grant", {30'd0, grant}, 32'd0);
        wait_start("tmo1");
        do_pkt(2'b10, 2, 1'b0, 1'b0, 16'd0);
        chk("tmo_pkt_cnt2", {16'd0, pkt_cnt}, 32'd8);
        wait_idle("tmo");

        // Reset asserted mid-SEND
        f_start = 1'b1;
        f_num   = 16'd55;
        sb.push_back({2'b01, 16'd55});
        tick();
        f_start = 1'b0;
        wait_start("mrst");
        tick();
        eth_tx_req  = 1'b1;
        eth_tx_done = 1'b1;
        sys_rst_n   = 1'b0;
        #1;
        chk_zero("mrst");
        eth_tx_req  = 1'b0;
        eth_tx_done = 1'b0;
        sb.delete();
        #3;
        sys_rst_n = 1'b1;
        repeat (8) tick();
        chk_zero("mrst_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
